uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular byte FIFO. Frames are start, DATA_BITS data
// bits LSB first, optional parity, STOP_BITS stop bits; every output is a flop.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          reset,
  // i_Tx_DV/o_Tx_Ready: a byte transfers on any rising edge where both are high;
  // a strobe while not ready is dropped and flagged on o_Tx_Overflow next cycle.
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Overflow,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done,
  output logic [2:0]                    o_dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [15:0]      CLK_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 ovf_q, ovf_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rd_data;
  logic                 wr_en;
  logic                 rd_en;
  logic                 bit_end;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign wr_en   = i_Tx_DV && (count_q < DEPTH_C);
  assign rd_en   = (state_q == S_IDLE) && (count_q != '0);
  assign bit_end = (clk_cnt_q == CLK_LAST);
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge i_Clock) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte[DATA_BITS-1:0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d < DEPTH_C);
    ovf_d   = i_Tx_DV && !wr_en;
  end

  // State register
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      ovf_q      <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (rd_en) begin
          shift_d  = rd_data;
          parity_d = (PARITY == 1) ? ~^rd_data : ^rd_data;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the line flop changes on bit boundaries.
  always_comb begin
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
      end
      S_DATA: begin
        serial_d = shift_d[0];
        active_d = 1'b1;
      end
      S_PARITY: begin
        serial_d = parity_d;
        active_d = 1'b1;
      end
      S_STOP: begin
        serial_d = 1'b1;
        active_d = 1'b1;
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_Tx_Ready    = ready_q;
  assign o_Fifo_Count  = count_q;
  assign o_Tx_Overflow = ovf_q;
  assign o_Tx_Active   = active_q;
  assign o_Tx_Serial   = serial_q;
  assign o_Tx_Done     = done_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 instance plus 7-bit even/odd parity
// instances with two stop bits, all at four clocks per bit and a 4-entry FIFO.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       dv_a, dv_e, dv_o;
  logic [7:0] tx_byte;

  logic       rdy_a, ovf_a, act_a, ser_a, done_a;
  logic [2:0] cnt_a, st_a;
  logic       rdy_e, ovf_e, act_e, ser_e, done_e;
  logic [2:0] cnt_e, st_e;
  logic       rdy_o, ovf_o, act_o, ser_o, done_o;
  logic [2:0] cnt_o, st_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  logic [7:0] exp_q[$];

  logic [7:0] rb;
  bit         rok;
  int         sent;
  int         guard;
  int         ovf_base;
  int         bad;
  int         cnt_tab[8];

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_Clock(clk), .reset(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(rdy_a), .o_Fifo_Count(cnt_a), .o_Tx_Overflow(ovf_a),
    .o_Tx_Active(act_a), .o_Tx_Serial(ser_a), .o_Tx_Done(done_a), .o_dbg_state(st_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_e (
    .i_Clock(clk), .reset(rst), .i_Tx_DV(dv_e), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(rdy_e), .o_Fifo_Count(cnt_e), .o_Tx_Overflow(ovf_e),
    .o_Tx_Active(act_e), .o_Tx_Serial(ser_e), .o_Tx_Done(done_e), .o_dbg_state(st_e)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
    .i_Clock(clk), .reset(rst), .i_Tx_DV(dv_o), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(rdy_o), .o_Fifo_Count(cnt_o), .o_Tx_Overflow(ovf_o),
    .o_Tx_Active(act_o), .o_Tx_Serial(ser_o), .o_Tx_Done(done_o), .o_dbg_state(st_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (ovf_a === 1'b1) ovf_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ser(input int sel);
    case (sel)
      0:       return ser_a;
      1:       return ser_e;
      default: return ser_o;
    endcase
  endfunction

  function automatic logic get_act(input int sel);
    case (sel)
      0:       return act_a;
      1:       return act_e;
      default: return act_o;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_e;
      default: return done_o;
    endcase
  endfunction

  function automatic logic [2:0] get_cnt(input int sel);
    case (sel)
      0:       return cnt_a;
      1:       return cnt_e;
      default: return cnt_o;
    endcase
  endfunction

  // Called in the write cycle N; frame bit 0 goes out first, four clocks per bit.
  task automatic check_frame(input int sel, input logic [15:0] frame, input int nbits, input string tag);
    int last_k;
    logic e_ser, e_act, e_done;
    last_k = 2 + 4 * nbits;
    for (int k = 1; k <= last_k + 1; k++) begin
      step();
      if (k == 1) begin
        dv_a = 1'b0;
        dv_e = 1'b0;
        dv_o = 1'b0;
        check_eq($sformatf("%s_cnt_pop", tag), get_cnt(sel), 1);
      end
      if (k == 2) check_eq($sformatf("%s_cnt_after_pop", tag), get_cnt(sel), 0);
      e_ser  = (k >= 2 && k < last_k) ? frame[(k - 2) / 4] : 1'b1;
      e_act  = (k >= 2 && k < last_k);
      e_done = (k == last_k);
      check_eq($sformatf("%s_ser@%0d", tag, k), get_ser(sel), e_ser);
      check_eq($sformatf("%s_act@%0d", tag, k), get_act(sel), e_act);
      check_eq($sformatf("%s_done@%0d", tag, k), get_done(sel), e_done);
    end
  endtask

  // Line decoder for the 8N1 instance: finds the start bit and samples mid-bit.
  task automatic recv_byte(output logic [7:0] b, output bit ok);
    int w;
    w  = 0;
    b  = '0;
    ok = 1'b0;
    while (ser_a !== 1'b0 && w < 300) begin
      step();
      w++;
    end
    if (ser_a !== 1'b0) return;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      repeat (4) step();
      b[i] = ser_a;
    end
    repeat (4) step();
    ok = (ser_a === 1'b1);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst     = 1'b1;
    dv_a    = 1'b0;
    dv_e    = 1'b0;
    dv_o    = 1'b0;
    tx_byte = 8'h00;
    repeat (3) step();

    // Reset state, with write strobes held high that must be ignored
    dv_a = 1'b1; dv_e = 1'b1; dv_o = 1'b1; tx_byte = 8'h5A;
    step();
    check_eq("rst_ser",   ser_a,  1);
    check_eq("rst_act",   act_a,  0);
    check_eq("rst_done",  done_a, 0);
    check_eq("rst_ovf",   ovf_a,  0);
    check_eq("rst_rdy",   rdy_a,  1);
    check_eq("rst_cnt",   cnt_a,  0);
    check_eq("rst_state", st_a,   0);
    check_eq("rst_ser_e", ser_e,  1);
    check_eq("rst_ser_o", ser_o,  1);
    rst = 1'b0; dv_a = 1'b0; dv_e = 1'b0; dv_o = 1'b0;
    step();
    check_eq("post_rst_cnt_a", cnt_a, 0);
    check_eq("post_rst_cnt_e", cnt_e, 0);
    check_eq("post_rst_ser_a", ser_a, 1);

    // 8N1 0xA5: start, 1,0,1,0,0,1,0,1, stop
    step();
    tx_byte = 8'hA5; dv_a = 1'b1;
    check_eq("a5_cnt_n", cnt_a, 0);
    check_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, "a5");

    // 7E2 / 7O2 with bit 7 set on input: data 1,0,1,0,1,0,1 then parity
    step();
    tx_byte = 8'hD5; dv_e = 1'b1;
    check_frame(1, 16'({2'b11, 1'b0, 7'h55, 1'b0}), 11, "even");
    step();
    tx_byte = 8'hD5; dv_o = 1'b1;
    check_frame(2, 16'({2'b11, 1'b1, 7'h55, 1'b0}), 11, "odd");

    // Back-to-back 0x00 then 0xFF
    begin : b2b
      logic [9:0] f1, f2;
      logic       e;
      int         dones;
      f1 = {1'b1, 8'h00, 1'b0};
      f2 = {1'b1, 8'hFF, 1'b0};
      dones = 0;
      step();
      tx_byte = 8'h00; dv_a = 1'b1;
      for (int k = 1; k <= 85; k++) begin
        step();
        if (k == 1) tx_byte = 8'hFF;
        if (k == 2) dv_a = 1'b0;
        if (k >= 2 && k <= 41)       e = f1[(k - 2) / 4];
        else if (k >= 43 && k <= 82) e = f2[(k - 43) / 4];
        else                         e = 1'b1;
        check_eq($sformatf("b2b_ser@%0d", k), ser_a, e);
        if (done_a === 1'b1) dones++;
        if (k == 42 || k == 83) check_eq($sformatf("b2b_done@%0d", k), done_a, 1);
      end
      check_eq("b2b_done_pulses", dones, 2);
    end

    // Overflow: strobe held for six cycles into a 4-deep FIFO
    cnt_tab  = '{0, 1, 1, 2, 3, 4, 4, 4};
    ovf_base = ovf_cnt;
    step();
    fork
      begin
        for (int k = 0; k <= 7; k++) begin
          if (k <= 5) begin
            dv_a = 1'b1;
            tx_byte = 8'h10 + 8'(k);
          end else begin
            dv_a = 1'b0;
          end
          check_eq($sformatf("ovf_rdy@%0d", k), rdy_a, (k <= 4));
          check_eq($sformatf("ovf_cnt@%0d", k), cnt_a, cnt_tab[k]);
          check_eq($sformatf("ovf_pulse@%0d", k), ovf_a, (k == 6));
          step();
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          recv_byte(rb, rok);
          check_eq($sformatf("ovf_rx_ok%0d", i), rok, 1);
          check_eq($sformatf("ovf_rx_byte%0d", i), rb, 8'h10 + 8'(i));
        end
      end
    join
    repeat (5) step();
    check_eq("ovf_pulse_count", ovf_cnt - ovf_base, 1);
    check_eq("ovf_drain_cnt", cnt_a, 0);
    check_eq("ovf_drain_rdy", rdy_a, 1);

    // Stream 20 bytes gated by ready; pointers wrap several times
    ovf_base = ovf_cnt;
    exp_q.delete();
    fork
      begin
        sent  = 0;
        guard = 0;
        while (sent < 20 && guard < 5000) begin
          if (rdy_a === 1'b1) begin
            dv_a    = 1'b1;
            tx_byte = 8'(sent * 37 + 3);
            exp_q.push_back(tx_byte);
            sent++;
          end else begin
            dv_a = 1'b0;
          end
          step();
          guard++;
        end
        dv_a = 1'b0;
        check_eq("stream_sent", sent, 20);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] eb;
          recv_byte(rb, rok);
          check_eq($sformatf("stream_rx_ok%0d", i), rok, 1);
          eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check_eq($sformatf("stream_rx_byte%0d", i), rb, eb);
        end
      end
    join
    check_eq("stream_no_ovf", ovf_cnt - ovf_base, 0);
    check_eq("stream_q_left", exp_q.size(), 0);
    repeat (5) step();

    // Reset mid-frame in DATA with three entries queued
    tx_byte = 8'h00; dv_a = 1'b1;
    step(); tx_byte = 8'h11;
    step(); tx_byte = 8'h22;
    step(); tx_byte = 8'h33;
    step(); dv_a = 1'b0;
    repeat (6) step();
    check_eq("mid_ser_pre", ser_a, 0);
    check_eq("mid_cnt_pre", cnt_a, 3);
    check_eq("mid_state_pre", st_a, 2);
    rst = 1'b1; dv_a = 1'b1; tx_byte = 8'h77;
    step();
    check_eq("mid_ser", ser_a, 1);
    check_eq("mid_cnt", cnt_a, 0);
    check_eq("mid_rdy", rdy_a, 1);
    check_eq("mid_done", done_a, 0);
    check_eq("mid_act", act_a, 0);
    check_eq("mid_state", st_a, 0);
    rst = 1'b0; dv_a = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (ser_a !== 1'b1 || done_a !== 1'b0 || act_a !== 1'b0) bad++;
    end
    check_eq("mid_line_quiet", bad, 0);
    check_eq("mid_cnt_end", cnt_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
